// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg: shared widths, stage-A record and case encoding for the mantissa normalizer
package fp_norm_pkg;
  localparam int SUM_W = 25;
  localparam int MANT_W = 24;
  localparam int EXP_W = 8;
  localparam int SHIFT_W = 5;
  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [EXP_W-1:0] exp;
    logic [SHIFT_W-1:0] lzc;
  } stage_a_t;
  typedef enum logic [1:0] {CARRY, ZERO, NORM, SHIFT} norm_case_t;
endpackage

// File: rtl/leading_zero_counter.sv
// leading_zero_counter: counts leading zeros of a word, returns W for an all-zero input
module leading_zero_counter #(
  parameter int W = 24,
  parameter int CW = 5
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count
);
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++)
      if (value[i]) count = CW'(W - 1 - i);
  end
endmodule

// File: rtl/mantissa_normalizer.sv
// mantissa_normalizer: two-stage valid/ready significand normalizer for the FP adder.
// Optional NORM_DENORM_CLAMP_EN limits the left shift so the exponent stays >= 1.
module mantissa_normalizer
  import fp_norm_pkg::*;
#(
  parameter int SUM_W = 25,
  parameter int MANT_W = 24,
  parameter int EXP_W = 8,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SUM_W-1:0]   sum_in,
  input  logic [EXP_W-1:0]   exp_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MANT_W-1:0]  mant_out,
  output logic               sticky_out,
  output logic               enable,
  output logic               increment_mode,
  output logic [SHIFT_W-1:0] increment_value,
  output logic               zero_out
);
  logic valid_a;
  stage_a_t a;
  logic [SHIFT_W-1:0] lzc;
  logic stage_b_ready;
  norm_case_t kind;
  logic [SHIFT_W-1:0] sh;
  leading_zero_counter #(.W(MANT_W), .CW(SHIFT_W)) u_lzc (
    .value(sum_in[MANT_W-1:0]),
    .count(lzc)
  );
  assign stage_b_ready = !out_valid || out_ready;
  assign in_ready = (!valid_a || stage_b_ready) && !flush;
  assign kind = a.sum[SUM_W-1] ? CARRY : a.sum == '0 ? ZERO : a.sum[MANT_W-1] ? NORM : SHIFT;
`ifdef NORM_DENORM_CLAMP_EN
  logic [EXP_W-1:0] exp_room;
  assign exp_room = a.exp - EXP_W'(1);
  assign sh = (a.exp <= EXP_W'(1)) ? '0 :
              (EXP_W'(a.lzc) < exp_room) ? a.lzc : SHIFT_W'(exp_room);
`else
  logic unused_exp;
  assign unused_exp = ^a.exp;
  assign sh = a.lzc;
`endif
  always_ff @(posedge clk) begin
    if (flush) begin
      valid_a <= 1'b0;
      a <= '0;
      out_valid <= 1'b0;
      mant_out <= '0;
      sticky_out <= 1'b0;
      enable <= 1'b0;
      increment_mode <= 1'b0;
      increment_value <= '0;
      zero_out <= 1'b0;
    end else begin
      if (in_ready) begin
        valid_a <= in_valid;
        if (in_valid) a <= '{sum: sum_in, exp: exp_in, lzc: lzc};
      end
      if (stage_b_ready) begin
        out_valid <= valid_a;
        if (valid_a) begin
          mant_out <= kind == CARRY ? a.sum[SUM_W-1:1] :
                      kind == SHIFT ? a.sum[MANT_W-1:0] << sh : a.sum[MANT_W-1:0];
          sticky_out <= kind == CARRY && a.sum[0];
          enable <= kind == CARRY || (kind == SHIFT && sh != '0);
          increment_mode <= kind == SHIFT && sh != '0;
          increment_value <= kind == SHIFT ? sh : '0;
          zero_out <= kind == ZERO;
        end
      end
    end
  end
endmodule

// File: tb/tb_mantissa_normalizer.sv
// tb_mantissa_normalizer: scoreboard bench with a behavioural normalization model
module tb_mantissa_normalizer;
  logic clk = 1'b0;
  logic flush = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [24:0] sum_in = '0;
  logic [7:0] exp_in = '0;
  logic in_ready, out_valid, sticky_out, enable, increment_mode, zero_out;
  logic [23:0] mant_out;
  logic [4:0] increment_value;

  typedef struct packed {
    logic [23:0] mant;
    logic sticky;
    logic en;
    logic mode;
    logic [4:0] val;
    logic zero;
  } res_t;

  res_t q[$];
  res_t dut_res;
  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 0;

  mantissa_normalizer dut (
    .clk(clk), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .exp_in(exp_in), .out_valid(out_valid), .out_ready(out_ready),
    .mant_out(mant_out), .sticky_out(sticky_out), .enable(enable),
    .increment_mode(increment_mode), .increment_value(increment_value), .zero_out(zero_out)
  );

  always #5 clk = ~clk;
  assign dut_res = {mant_out, sticky_out, enable, increment_mode, increment_value, zero_out};

  function automatic res_t model(logic [24:0] s, logic [7:0] e);
    res_t r = '0;
    int n = 0;
    int sh;
    logic [23:0] m;
    if (s[24]) begin
      r.mant = s[24:1];
      r.sticky = s[0];
      r.en = 1'b1;
    end else if (s == 0) begin
      r.zero = 1'b1;
    end else begin
      m = s[23:0];
      while (!m[23]) begin
        m = m << 1;
        n++;
      end
      sh = n;
`ifdef NORM_DENORM_CLAMP_EN
      if (e <= 1) sh = 0;
      else if (int'(e) - 1 < sh) sh = int'(e) - 1;
`else
      if (e === 8'hxx) sh = n;
`endif
      r.mant = s[23:0] << sh;
      r.en = sh != 0;
      r.mode = sh != 0;
      r.val = 5'(sh);
    end
    return r;
  endfunction

  function automatic logic [24:0] gen_sum();
    int k = $urandom_range(0, 5);
    if (k == 0) return {1'b1, 24'($urandom)};
    if (k == 1) return '0;
    if (k == 2) return {2'b01, 23'($urandom)};
    return 25'(24'($urandom) >> $urandom_range(0, 23));
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [24:0] s, input logic [7:0] e, input logic r,
                      output bit acc);
    @(negedge clk);
    in_valid = v;
    sum_in = s;
    exp_in = e;
    out_ready = r;
    #1;
    acc = v && in_ready;
    if (acc) q.push_back(model(s, e));
  endtask

  task automatic directed(string name, logic [24:0] s, logic [7:0] e, res_t exp);
    bit a;
    step(1'b1, s, e, 1'b1, a);
    check({name, "_accept"}, 64'(a), 1);
    step(1'b0, '0, '0, 1'b1, a);
    check({name, "_not_yet"}, 64'(out_valid), 0);
    step(1'b0, '0, '0, 1'b1, a);
    check({name, "_valid"}, 64'(out_valid), 1);
    check(name, 64'(dut_res), 64'(exp));
  endtask

  task automatic drain();
    bit a;
    for (int c = 0; c < 50; c++) begin
      if (q.size() == 0 && !out_valid) break;
      step(1'b0, '0, '0, 1'b1, a);
    end
    check("drain_empty", 64'(q.size()), 0);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  initial begin
    res_t prev;
    bit stalled;
    stalled = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (stalled) check("stall_hold", {out_valid, dut_res}, {1'b1, prev});
        stalled = out_valid && !out_ready && !flush;
        prev = dut_res;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %h expected none", dut_res);
          end else begin
            check("result", 64'(dut_res), 64'(q.pop_front()));
          end
        end
      end else begin
        stalled = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit a;
    int idx;
    logic [24:0] items [3];
    logic [7:0] e;
    flush = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 0);
    check("reset_outputs", 64'(dut_res), 0);
    check("reset_in_ready", 64'(in_ready), 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("in_ready_after_reset", 64'(in_ready), 1);
    mon_en = 1;

    directed("carry", 25'h1800001, 8'd10, res_t'({24'hC00000, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0}));
    directed("normalized", 25'h0800000, 8'd10, res_t'({24'h800000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0}));
    directed("deep_shift", 25'h0000001, 8'd100, res_t'({24'h800000, 1'b0, 1'b1, 1'b1, 5'd23, 1'b0}));
`ifdef NORM_DENORM_CLAMP_EN
    directed("deep_clamped", 25'h0000001, 8'd5, res_t'({24'h000010, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0}));
    directed("denormal", 25'h0000300, 8'd1, res_t'({24'h000300, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0}));
`else
    directed("deep_exp5", 25'h0000001, 8'd5, res_t'({24'h800000, 1'b0, 1'b1, 1'b1, 5'd23, 1'b0}));
    directed("mid_shift", 25'h0000300, 8'd1, res_t'({24'hC00000, 1'b0, 1'b1, 1'b1, 5'd14, 1'b0}));
`endif
    directed("zero", 25'h0000000, 8'd7, res_t'({24'h000000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1}));
    drain();

    // Backpressure: only two inputs fit while the output is stalled.
    for (int i = 0; i < 3; i++) items[i] = gen_sum();
    e = 8'($urandom);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(idx < 3, idx < 3 ? items[idx] : '0, e, 1'b0, a);
      if (a) idx++;
    end
    check("bp_accepts", 64'(idx), 2);
    check("bp_in_ready", 64'(in_ready), 0);
    for (int c = 0; c < 10 && idx < 3; c++) begin
      step(1'b1, items[idx], e, 1'b1, a);
      if (a) idx++;
    end
    check("bp_third_accepted", 64'(idx), 3);
    drain();

    // Flush with both stages occupied.
    step(1'b1, gen_sum(), 8'd50, 1'b0, a);
    check("flush_fill_a", 64'(a), 1);
    step(1'b1, gen_sum(), 8'd50, 1'b0, a);
    check("flush_fill_b", 64'(a), 1);
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    sum_in = gen_sum();
    out_ready = 1'b0;
    q.delete();
    #1;
    check("flush_in_ready_low", 64'(in_ready), 0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("flush_out_valid", 64'(out_valid), 0);
    check("flush_outputs", 64'(dut_res), 0);
    check("flush_in_ready", 64'(in_ready), 1);
    repeat (4) step(1'b0, '0, '0, 1'b1, a);

    for (int c = 0; c < 1500; c++)
      step($urandom_range(0, 3) != 0, gen_sum(), 8'($urandom), $urandom_range(0, 3) != 0, a);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
